// File: rtl/pin_lock_ctrl.sv
// ============================================================================
// Module   : pin_lock_ctrl
// Summary  : 4-digit BCD PIN entry lock with an unlock timer, error pulse and
//            sticky alarm after repeated consecutive failures.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pin_lock_ctrl #(
  parameter logic [15:0] PIN_CODE      = 16'h1234,
  parameter int unsigned MAX_TRIES     = 3,
  parameter int unsigned UNLOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_vld,
  input  logic       clr_alarm,
  output logic       open,
  output logic       error,
  output logic       alarm,
  output logic [1:0] try_cnt
);

  localparam logic [1:0] C_MAX_TRIES = 2'(MAX_TRIES);
  localparam logic [3:0] C_OPEN_LOAD = 4'(UNLOCK_CYCLES - 1);
  localparam logic [1:0] C_LAST_POS  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_OPEN  = 3'd2,
    S_ERR   = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_entry;
  logic [15:0] w_entry_nxt;
  logic [1:0]  r_pos;
  logic [1:0]  w_pos_nxt;
  logic [1:0]  r_try;
  logic [1:0]  w_try_nxt;
  logic [3:0]  r_open_cnt;
  logic [3:0]  w_open_cnt_nxt;

  logic        w_digit_ok;
  logic        w_match;
  logic        w_last_try;

  assign w_digit_ok = (digit <= 4'd9);
  assign w_match    = (r_entry == PIN_CODE);
  // Compare at 3 bits so try+1 cannot wrap; >= also covers a saturated count.
  assign w_last_try = (({1'b0, r_try} + 3'd1) >= {1'b0, C_MAX_TRIES});

  always_comb begin
    w_state_nxt    = r_state;
    w_entry_nxt    = r_entry;
    w_pos_nxt      = r_pos;
    w_try_nxt      = r_try;
    w_open_cnt_nxt = r_open_cnt;

    case (r_state)
      S_IDLE: begin
        if (digit_vld) begin
          if (w_digit_ok) begin
            w_entry_nxt = {r_entry[11:0], digit};
            w_pos_nxt   = r_pos + 2'd1;
            if (r_pos == C_LAST_POS) begin
              w_state_nxt = S_CHECK;
            end
          end else begin
            w_entry_nxt = 16'h0000;
            w_pos_nxt   = 2'd0;
          end
        end
      end

      S_CHECK: begin
        w_entry_nxt = 16'h0000;
        if (w_match) begin
          w_try_nxt      = 2'd0;
          w_open_cnt_nxt = C_OPEN_LOAD;
          w_state_nxt    = S_OPEN;
        end else if (w_last_try) begin
          w_try_nxt   = C_MAX_TRIES;
          w_state_nxt = S_LOCK;
        end else begin
          w_try_nxt   = r_try + 2'd1;
          w_state_nxt = S_ERR;
        end
      end

      S_OPEN: begin
        if (r_open_cnt != 4'd0) begin
          w_open_cnt_nxt = r_open_cnt - 4'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ERR: begin
        w_state_nxt = S_IDLE;
      end

      S_LOCK: begin
        if (clr_alarm) begin
          w_try_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry    <= 16'h0000;
      r_pos      <= 2'd0;
      r_try      <= 2'd0;
      r_open_cnt <= 4'd0;
    end else begin
      r_entry    <= w_entry_nxt;
      r_pos      <= w_pos_nxt;
      r_try      <= w_try_nxt;
      r_open_cnt <= w_open_cnt_nxt;
    end
  end

  assign open    = (r_state == S_OPEN);
  assign error   = (r_state == S_ERR);
  assign alarm   = (r_state == S_LOCK);
  assign try_cnt = r_try;

endmodule

`default_nettype wire

// File: tb/tb_pin_lock_ctrl.sv
// ============================================================================
// Module   : tb_pin_lock_ctrl
// Summary  : Directed vector-table bench for pin_lock_ctrl (default params).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pin_lock_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       digit_vld;
  logic       clr_alarm;
  logic       open;
  logic       error;
  logic       alarm;
  logic [1:0] try_cnt;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic       vld;
    logic [3:0] d;
    logic       clr;
    logic       o;
    logic       e;
    logic       a;
    logic [1:0] t;
  } vec_t;

  vec_t vq[$];

  pin_lock_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit     (digit),
    .digit_vld (digit_vld),
    .clr_alarm (clr_alarm),
    .open      (open),
    .error     (error),
    .alarm     (alarm),
    .try_cnt   (try_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic o, input logic e,
                         input logic a, input logic [1:0] t);
    chk({tag, ".open"},    {3'b0, open},  {3'b0, o});
    chk({tag, ".error"},   {3'b0, error}, {3'b0, e});
    chk({tag, ".alarm"},   {3'b0, alarm}, {3'b0, a});
    chk({tag, ".try_cnt"}, {2'b0, try_cnt}, {2'b0, t});
  endtask

  // Vector: inputs for one cycle, expected outputs just after the next edge.
  task automatic push(input logic vld, input logic [3:0] d, input logic clr,
                      input logic o, input logic e, input logic a, input logic [1:0] t);
    vec_t v;
    v.vld = vld; v.d = d; v.clr = clr; v.o = o; v.e = e; v.a = a; v.t = t;
    vq.push_back(v);
  endtask

  task automatic idle(input logic o, input logic e, input logic a,
                      input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) push(1'b0, 4'd0, 1'b0, o, e, a, t);
  endtask

  task automatic entry(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic [1:0] t);
    push(1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    push(1'b1, d1, 1'b0, 1'b0, 1'b0, 1'b0, t);
    push(1'b1, d2, 1'b0, 1'b0, 1'b0, 1'b0, t);
    push(1'b1, d3, 1'b0, 1'b0, 1'b0, 1'b0, t);
  endtask

  task automatic step(input logic vld, input logic [3:0] d, input logic clr);
    digit_vld = vld;
    digit     = d;
    clr_alarm = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    digit     = 4'd0;
    digit_vld = 1'b0;
    clr_alarm = 1'b0;

    // Correct code: open for 8 cycles starting the edge after CHECK.
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
    idle(1'b1, 1'b0, 1'b0, 2'd0, 8);
    idle(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // One wrong code, then correct code clears the count.
    entry(4'd1, 4'd2, 4'd3, 4'd5, 2'd0);
    idle(1'b0, 1'b1, 1'b0, 2'd1, 1);
    idle(1'b0, 1'b0, 1'b0, 2'd1, 1);
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd1);
    idle(1'b1, 1'b0, 1'b0, 2'd0, 8);
    idle(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // Three failures: lockout without a third error, code ignored, then clear.
    entry(4'd9, 4'd9, 4'd9, 4'd9, 2'd0);
    idle(1'b0, 1'b1, 1'b0, 2'd1, 1);
    idle(1'b0, 1'b0, 1'b0, 2'd1, 1);
    entry(4'd9, 4'd9, 4'd9, 4'd9, 2'd1);
    idle(1'b0, 1'b1, 1'b0, 2'd2, 1);
    idle(1'b0, 1'b0, 1'b0, 2'd2, 1);
    entry(4'd9, 4'd9, 4'd9, 4'd9, 2'd2);
    idle(1'b0, 1'b0, 1'b1, 2'd3, 1);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    push(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    push(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    push(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    idle(1'b0, 1'b0, 1'b1, 2'd3, 2);
    push(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
    idle(1'b1, 1'b0, 1'b0, 2'd0, 8);
    idle(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // Invalid digit aborts silently; try_cnt held at 1 until the good code.
    entry(4'd5, 4'd5, 4'd5, 4'd5, 2'd0);
    idle(1'b0, 1'b1, 1'b0, 2'd1, 1);
    idle(1'b0, 1'b0, 1'b0, 2'd1, 1);
    push(1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    push(1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    push(1'b1, 4'hA,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd1);
    idle(1'b1, 1'b0, 1'b0, 2'd0, 8);
    idle(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // Digits and clr_alarm during CHECK/OPEN are dropped; open runs full length.
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd0);
    for (int i = 0; i < 4; i++) push(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) push(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    push(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // Digit in the ERR cycle is dropped too.
    entry(4'd5, 4'd5, 4'd5, 4'd5, 2'd0);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
    push(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    entry(4'd1, 4'd2, 4'd3, 4'd4, 2'd1);
    idle(1'b1, 1'b0, 1'b0, 2'd0, 8);
    idle(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // Reset state.
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].vld, vq[i].d, vq[i].clr);
      chk_all($sformatf("vec%0d", i), vq[i].o, vq[i].e, vq[i].a, vq[i].t);
    end

    // Asynchronous reset mid-entry with a nonzero try count.
    step(1'b1, 4'd5, 1'b0); step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd5, 1'b0); step(1'b1, 4'd5, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("pre_rst", 1'b0, 1'b0, 1'b0, 2'd1);
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'd2, 1'b0);
    digit_vld = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk_all("rst_mid_entry", 1'b0, 1'b0, 1'b0, 2'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd4, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("open_after_rst", 1'b1, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset mid-OPEN forces outputs low at once.
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("mid_open", 1'b1, 1'b0, 1'b0, 2'd0);
    #3 rst_n = 1'b0;
    #1 chk_all("rst_mid_open", 1'b0, 1'b0, 1'b0, 2'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle_after_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b1, 4'd1, 1'b0); step(1'b1, 4'd2, 1'b0);
    step(1'b1, 4'd3, 1'b0); step(1'b1, 4'd4, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    chk_all("open_after_rst2", 1'b1, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
